// File: rtl/credit_rx_buffer.sv
// ---------------------------------------------------------------------------
// credit_rx_buffer
//   Receive end of a 16-bit credit-based router link. Incoming flits are
//   buffered in a DEPTH-entry FIFO and presented to the local consumer with
//   a valid/ready handshake. Every flit handed to the consumer returns one
//   credit upstream as a single-cycle pulse on credit_o, issued the cycle
//   after the pop.
//
// Optional build macro:
//   CREDIT_RX_BYPASS_EN - when the FIFO is empty, an arriving flit is shown
//                         on data_o/valid_o in the same cycle. If the consumer
//                         takes it that cycle, the flit never enters the FIFO.
//                         When the macro is undefined, the outputs have no
//                         combinational path from data_i/valid_i.
//
// Ports:
//   clk        in   rising-edge clock
//   reset      in   synchronous active-low reset (0 = reset)
//   data_i     in   [DATA_W]   flit from upstream link
//   valid_i    in   data_i carries a flit this cycle
//   data_o     out  [DATA_W]   head flit to consumer
//   valid_o    out  head flit present
//   ready_i    in   consumer accepts head flit this cycle
//   credit_o   out  one-cycle pulse per flit consumed
//   count_o    out  [PTR_W+1]  FIFO occupancy, 0..DEPTH
//   overflow_o out  sticky: a flit arrived while full with no pop
// ---------------------------------------------------------------------------
module credit_rx_buffer #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 4,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] data_i,
  input  logic              valid_i,
  output logic [DATA_W-1:0] data_o,
  output logic              valid_o,
  input  logic              ready_i,
  output logic              credit_o,
  output logic [PTR_W:0]    count_o,
  output logic              overflow_o
);

  localparam logic [PTR_W:0]   FULL_C = (PTR_W+1)'(DEPTH);
  localparam logic [PTR_W-1:0] ONE_P  = PTR_W'(1);
  localparam logic [PTR_W:0]   ONE_C  = (PTR_W+1)'(1);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [PTR_W:0]    r_count;
  logic              r_credit;
  logic              r_ovf;

  logic w_empty;
  logic w_full;
  logic w_byp;       // flit passes straight through an empty FIFO
  logic w_take;      // consumer handshake this cycle (FIFO or bypass)
  logic w_fifo_pop;  // head of FIFO leaves
  logic w_fifo_push; // data_i is written into FIFO
  logic w_drop;      // arrival while full with no pop to make room

  assign w_empty = (r_count == '0);
  assign w_full  = (r_count == FULL_C);

`ifdef CREDIT_RX_BYPASS_EN
  assign w_byp   = w_empty & valid_i;
  assign valid_o = ~w_empty | w_byp;
  assign data_o  = w_byp ? data_i : r_mem[r_rd_ptr];
`else
  assign w_byp   = 1'b0;
  assign valid_o = ~w_empty;
  assign data_o  = r_mem[r_rd_ptr];
`endif

  assign w_take = valid_o & ready_i;

  // A bypassed flit is consumed without touching pointers or the counter.
  assign w_fifo_pop = w_take & ~w_byp;

  // When full, a same-cycle pop frees the slot being written.
  assign w_fifo_push = valid_i & ~(w_byp & ready_i) & (~w_full | w_fifo_pop);
  assign w_drop      = valid_i & w_full & ~w_fifo_pop;

  // Storage is not reset; contents are meaningless until written.
  always_ff @(posedge clk) begin
    if (w_fifo_push) r_mem[r_wr_ptr] <= data_i;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_credit <= 1'b0;
      r_ovf    <= 1'b0;
    end else begin
      if (w_fifo_push) r_wr_ptr <= r_wr_ptr + ONE_P;
      if (w_fifo_pop)  r_rd_ptr <= r_rd_ptr + ONE_P;
      case ({w_fifo_push, w_fifo_pop})
        2'b10:   r_count <= r_count + ONE_C;
        2'b01:   r_count <= r_count - ONE_C;
        default: r_count <= r_count;
      endcase
      // One pulse per consumed flit, no coalescing.
      r_credit <= w_take;
      if (w_drop) r_ovf <= 1'b1;
    end
  end

  assign credit_o   = r_credit;
  assign count_o    = r_count;
  assign overflow_o = r_ovf;

endmodule

// File: tb/tb_credit_rx_buffer.sv
// ---------------------------------------------------------------------------
// tb_credit_rx_buffer
//   Scoreboard bench: accepted flits are queued when driven, and compared
//   against data_o when the consumer handshake occurs. Occupancy, credit and
//   overflow expectations come from a small reference model kept per cycle.
// ---------------------------------------------------------------------------
module tb_credit_rx_buffer;

  localparam int DATA_W = 16;
  localparam int DEPTH  = 4;
  localparam int PTR_W  = $clog2(DEPTH);
`ifdef CREDIT_RX_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic              clk;
  logic              reset;
  logic [DATA_W-1:0] data_i;
  logic              valid_i;
  logic [DATA_W-1:0] data_o;
  logic              valid_o;
  logic              ready_i;
  logic              credit_o;
  logic [PTR_W:0]    count_o;
  logic              overflow_o;

  credit_rx_buffer #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
    .clk        (clk),
    .reset      (reset),
    .data_i     (data_i),
    .valid_i    (valid_i),
    .data_o     (data_o),
    .valid_o    (valid_o),
    .ready_i    (ready_i),
    .credit_o   (credit_o),
    .count_o    (count_o),
    .overflow_o (overflow_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // reference model state
  logic [DATA_W-1:0] sb_q[$];
  bit m_known  = 1'b0;
  bit m_credit = 1'b0;
  bit m_ovf    = 1'b0;
  int n_credit = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // One clock cycle: drive, check outputs mid-cycle, advance model at edge.
  task automatic cyc(input logic rst_n, input logic v, input logic [DATA_W-1:0] d,
                     input logic r);
    bit byp, mvalid, take;
    int mcount;
    reset = rst_n; valid_i = v; data_i = d; ready_i = r;
    @(negedge clk);
    mcount = sb_q.size();
    byp    = BYP && (mcount == 0) && v;
    mvalid = (mcount != 0) || byp;
    take   = mvalid && r;
    if (m_known) begin
      chk("valid_o", 32'(valid_o), 32'(mvalid));
      chk("count_o", 32'(count_o), 32'(mcount));
      chk("credit_o", 32'(credit_o), 32'(m_credit));
      chk("overflow_o", 32'(overflow_o), 32'(m_ovf));
      if (mvalid) chk("data_o", 32'(data_o), byp ? 32'(d) : 32'(sb_q[0]));
      if (credit_o === 1'b1) n_credit++;
    end
    @(posedge clk);
    if (!rst_n) begin
      sb_q.delete();
      m_credit = 1'b0;
      m_ovf    = 1'b0;
      m_known  = 1'b1;
    end else if (m_known) begin
      m_credit = take;
      if (!(byp && r)) begin
        if (take) void'(sb_q.pop_front());
        if (v) begin
          if (mcount < DEPTH || take) sb_q.push_back(d);
          else m_ovf = 1'b1;
        end
      end
    end
    #1;
  endtask

  task automatic idle(input int n, input logic r);
    for (int i = 0; i < n; i++) cyc(1'b1, 1'b0, '0, r);
  endtask

  initial begin
    reset = 1'b0; valid_i = 1'b0; data_i = '0; ready_i = 1'b0;

    // reset then idle
    cyc(1'b0, 1'b0, '0, 1'b0);
    cyc(1'b0, 1'b0, '0, 1'b0);
    idle(10, 1'b0);
    chk("idle_count", 32'(count_o), 32'd0);

    // single flit, consumer always ready
    cyc(1'b1, 1'b1, 16'hA5A5, 1'b1);
    idle(4, 1'b1);
    chk("single_empty", 32'(valid_o), 32'd0);

    // fill then drain in order
    n_credit = 0;
    for (int i = 1; i <= DEPTH; i++) cyc(1'b1, 1'b1, 16'(i), 1'b0);
    chk("fill_count", 32'(count_o), 32'(DEPTH));
    chk("fill_head", 32'(data_o), 32'h0001);
    idle(DEPTH + 2, 1'b1);
    chk("drain_count", 32'(count_o), 32'd0);
    chk("drain_credits", 32'(n_credit), 32'(DEPTH));

    // simultaneous push/pop at full
    for (int i = 1; i <= DEPTH; i++) cyc(1'b1, 1'b1, 16'(i), 1'b0);
    cyc(1'b1, 1'b1, 16'h0005, 1'b1);
    chk("full_pp_count", 32'(count_o), 32'(DEPTH));
    chk("full_pp_ovf", 32'(overflow_o), 32'd0);
    chk("full_pp_head", 32'(data_o), 32'h0002);
    idle(DEPTH + 2, 1'b1);

    // overflow: dropped flit, sticky flag
    for (int i = 1; i <= DEPTH; i++) cyc(1'b1, 1'b1, 16'h0010 + 16'(i), 1'b0);
    cyc(1'b1, 1'b1, 16'hDEAD, 1'b0);
    chk("ovf_set", 32'(overflow_o), 32'd1);
    chk("ovf_count", 32'(count_o), 32'(DEPTH));
    idle(DEPTH + 3, 1'b1);
    chk("ovf_hold", 32'(overflow_o), 32'd1);
    chk("ovf_drained", 32'(count_o), 32'd0);

    // mid-operation reset discards flits and their credits
    for (int i = 0; i < 3; i++) cyc(1'b1, 1'b1, 16'h0100 + 16'(i), 1'b0);
    cyc(1'b0, 1'b0, '0, 1'b0);
    n_credit = 0;
    chk("mrst_count", 32'(count_o), 32'd0);
    chk("mrst_ovf", 32'(overflow_o), 32'd0);
    idle(6, 1'b1);
    chk("mrst_credits", 32'(n_credit), 32'd0);

    // mixed traffic with pseudo-random valid/ready
    for (int i = 0; i < 200; i++) begin
      logic v, r;
      v = ($urandom_range(0, 3) != 0) && (sb_q.size() < DEPTH);
      r = ($urandom_range(0, 2) != 0);
      cyc(1'b1, v, 16'($urandom), r);
    end
    idle(DEPTH + 2, 1'b1);
    chk("mix_ovf", 32'(overflow_o), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
